// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity encodings, FSM state
// types and the parameter legality check evaluated at elaboration.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    function automatic bit cfg_legal(input int clock_divide, input int oversample,
                                     input int data_bits, input int parity,
                                     input int stop_bits);
        return (clock_divide >= 1) && (oversample >= 4) && (oversample % 2 == 0) &&
               (data_bits >= 5) && (data_bits <= 9) &&
               (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
               (stop_bits >= 1) && (stop_bits <= 2);
    endfunction

endpackage

// File: rtl/uart_cfg_if.sv
// Byte-stream side of the UART: valid/ready transmit port and receive strobe.
interface uart_cfg_if #(parameter int DATA_BITS = 8);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_busy;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_busy, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_busy
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_busy, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_busy
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Restartable oversample tick generator: one tick every CLOCK_DIVIDE cycles,
// OVERSAMPLE ticks per bit, flagging the three mid-bit sample ticks and bit end.
module uart_baud_tick #(
    parameter int CLOCK_DIVIDE = 7,
    parameter int OVERSAMPLE   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick,
    output logic sample_pt,
    output logic bit_end
);
    localparam int DIV_W = $clog2(CLOCK_DIVIDE - 1) + 1;
    localparam int OS_W  = $clog2(OVERSAMPLE - 1) + 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  SMP_0    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMP_1    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SMP_2    = OS_W'(OVERSAMPLE / 2 + 1);

    logic [DIV_W-1:0] div_cnt;
    logic [OS_W-1:0]  os_cnt;

    assign tick      = (div_cnt == '0);
    assign sample_pt = tick && (os_cnt == SMP_0 || os_cnt == SMP_1 || os_cnt == SMP_2);
    assign bit_end   = tick && (os_cnt == OS_LAST);

    // NOTE: registers take <= so every flop samples pre-edge values; = here would chain updates within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= DIV_LOAD;
            os_cnt  <= '0;
        end else if (restart) begin
            div_cnt <= DIV_LOAD;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= DIV_LOAD;
            os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/uart_cfg.sv
// Configurable full-duplex UART: independent TX and RX state machines, each
// paced by its own uart_baud_tick; RX uses 2-of-3 majority mid-bit sampling.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVIDE = 7,
    parameter int OVERSAMPLE   = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    uart_cfg_if.slave  bus
);
    if (!cfg_legal(CLOCK_DIVIDE, OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS)) begin : g_cfg_illegal
        $error("uart_cfg: illegal parameter combination");
    end

    localparam bit HAS_PARITY = (PARITY != PAR_NONE);
    localparam bit IS_ODD     = (PARITY == PAR_ODD);
    localparam int BIT_W      = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    logic tx_tick, tx_sample, tx_bit_end, tx_restart;
    logic rx_tick, rx_sample, rx_bit_end, rx_restart;

    uart_baud_tick #(.CLOCK_DIVIDE(CLOCK_DIVIDE), .OVERSAMPLE(OVERSAMPLE)) u_tx_tick (
        .clk(clk), .rst_n(rst_n), .restart(tx_restart),
        .tick(tx_tick), .sample_pt(tx_sample), .bit_end(tx_bit_end)
    );

    uart_baud_tick #(.CLOCK_DIVIDE(CLOCK_DIVIDE), .OVERSAMPLE(OVERSAMPLE)) u_rx_tick (
        .clk(clk), .rst_n(rst_n), .restart(rx_restart),
        .tick(rx_tick), .sample_pt(rx_sample), .bit_end(rx_bit_end)
    );

    // Divider outputs each path does not need.
    logic unused_ticks;
    assign unused_ticks = &{1'b0, tx_tick, tx_sample, rx_tick, rx_bit_end};

    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BIT_W-1:0]     tx_bit;
    logic                 tx_stop_cnt;
    logic                 tx_par;
    logic                 tx_ready_q, tx_busy_q;

    assign tx_restart = bus.tx_valid && tx_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            tx          <= 1'b1;
            tx_shift    <= '0;
            tx_bit      <= '0;
            tx_stop_cnt <= 1'b0;
            tx_par      <= 1'b0;
            tx_ready_q  <= 1'b1;
            tx_busy_q   <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_restart) begin
                    tx_shift   <= bus.tx_data;
                    tx_par     <= (^bus.tx_data) ^ IS_ODD;
                    tx         <= 1'b0;
                    tx_ready_q <= 1'b0;
                    tx_busy_q  <= 1'b1;
                    tx_state   <= TX_START;
                end
                TX_START: if (tx_bit_end) begin
                    tx       <= tx_shift[0];
                    tx_bit   <= '0;
                    tx_state <= TX_DATA;
                end
                TX_DATA: if (tx_bit_end) begin
                    if (tx_bit == LAST_BIT) begin
                        tx_stop_cnt <= 1'b0;
                        tx          <= HAS_PARITY ? tx_par : 1'b1;
                        tx_state    <= HAS_PARITY ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_shift <= tx_shift >> 1;
                        tx       <= tx_shift[1];
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end
                TX_PARITY: if (tx_bit_end) begin
                    tx       <= 1'b1;
                    tx_state <= TX_STOP;
                end
                TX_STOP: if (tx_bit_end) begin
                    if (tx_stop_cnt == STOP_LAST) begin
                        tx_ready_q <= 1'b1;
                        tx_busy_q  <= 1'b0;
                        tx_state   <= TX_IDLE;
                    end else begin
                        tx_stop_cnt <= 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic [1:0]           rx_sync;
    logic                 rxs;
    rx_state_t            rx_state;
    logic [1:0]           rx_smp_cnt;
    logic [1:0]           rx_smp;
    logic                 rx_maj, rx_decide;
    logic [DATA_BITS-1:0] rx_shift;
    logic [BIT_W-1:0]     rx_bit;
    logic                 rx_par_bit;
    logic                 rx_valid_q, rx_perr_q, rx_ferr_q, rx_busy_q;
    logic [DATA_BITS-1:0] rx_data_q;

    assign rxs        = rx_sync[1];
    assign rx_restart = (rx_state == RX_IDLE) && !rxs;
    assign rx_maj     = (rx_smp[1] & rx_smp[0]) | (rx_smp[1] & rxs) | (rx_smp[0] & rxs);
    assign rx_decide  = rx_sample && (rx_smp_cnt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_smp_cnt <= '0;
            rx_smp     <= '0;
            rx_shift   <= '0;
            rx_bit     <= '0;
            rx_par_bit <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rx_sample) begin
                rx_smp_cnt <= rx_decide ? 2'd0 : rx_smp_cnt + 1'b1;
                rx_smp     <= {rx_smp[0], rxs};
            end
            case (rx_state)
                RX_IDLE: begin
                    rx_smp_cnt <= '0;
                    if (!rxs) begin
                        rx_busy_q <= 1'b1;
                        rx_state  <= RX_START;
                    end
                end
                RX_START: if (rx_decide) begin
                    rx_bit    <= '0;
                    rx_busy_q <= !rx_maj;
                    rx_state  <= rx_maj ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_decide) begin
                    rx_shift <= {rx_maj, rx_shift[DATA_BITS-1:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    if (rx_bit == LAST_BIT) rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                end
                RX_PARITY: if (rx_decide) begin
                    rx_par_bit <= rx_maj;
                    rx_state   <= RX_STOP;
                end
                RX_STOP: if (rx_decide) begin
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= rx_shift;
                    rx_perr_q  <= HAS_PARITY && (rx_par_bit != ((^rx_shift) ^ IS_ODD));
                    rx_ferr_q  <= !rx_maj;
                    rx_busy_q  <= !rx_maj;
                    rx_state   <= rx_maj ? RX_IDLE : RX_WAIT_HIGH;
                end
                RX_WAIT_HIGH: if (rxs) begin
                    rx_busy_q <= 1'b0;
                    rx_state  <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign bus.tx_ready      = tx_ready_q;
    assign bus.tx_busy       = tx_busy_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_busy       = rx_busy_q;
endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: 8N1 transmit timing, 7E2 loopback, 8O1 parity
// error with a glitched sample, false start, break recovery and mid-frame reset.
module tb_uart_cfg;
    localparam int BIT_CYC = 32;

    logic clk;
    logic rst_n;
    logic loop_a, rx_a_drv, rx_c;
    logic tx_a, tx_b, tx_c;
    wire  rx_a = loop_a ? tx_a : rx_a_drv;

    int checks   = 0;
    int failures = 0;
    int a_cnt = 0, b_cnt = 0, c_cnt = 0;
    int a0, b0, c0;
    logic [7:0] word;

    uart_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_cfg_if #(.DATA_BITS(7)) if_b ();
    uart_cfg_if #(.DATA_BITS(8)) if_c ();

    uart_cfg #(.CLOCK_DIVIDE(2), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .rst_n(rst_n), .rx(rx_a), .tx(tx_a), .bus(if_a));
    uart_cfg #(.CLOCK_DIVIDE(2), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
        dut_b (.clk(clk), .rst_n(rst_n), .rx(tx_b), .tx(tx_b), .bus(if_b));
    uart_cfg #(.CLOCK_DIVIDE(2), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        dut_c (.clk(clk), .rst_n(rst_n), .rx(rx_c), .tx(tx_c), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if_a.rx_valid) a_cnt++;
        if (if_b.rx_valid) b_cnt++;
        if (if_c.rx_valid) c_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 2000000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_level(input int which, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (which == 0) rx_a_drv = v;
            else            rx_c = v;
        end
    endtask

    // Bits are sent LSB first, BIT_CYC cycles each; cycle 'glitch' is inverted.
    task automatic drive_frame(input int which, input logic [15:0] bits,
                               input int nbits, input int glitch);
        logic v;
        for (int c = 0; c < nbits * BIT_CYC; c++) begin
            @(negedge clk);
            v = bits[c / BIT_CYC] ^ (c == glitch);
            if (which == 0) rx_a_drv = v;
            else            rx_c = v;
        end
    endtask

    task automatic send_a(input logic [7:0] d);
        @(negedge clk);
        if_a.tx_valid = 1'b1;
        if_a.tx_data  = d;
        @(negedge clk);
        if_a.tx_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        loop_a = 1'b0; rx_a_drv = 1'b1; rx_c = 1'b1;
        if_a.tx_valid = 1'b0; if_a.tx_data = '0;
        if_b.tx_valid = 1'b0; if_b.tx_data = '0;
        if_c.tx_valid = 1'b0; if_c.tx_data = '0;
        idle(4);
        rst_n = 1'b1;
        idle(2);

        // Reset state
        check("reset_tx", tx_a, 1'b1);
        check("reset_tx_ready", if_a.tx_ready, 1'b1);
        check("reset_tx_busy", if_a.tx_busy, 1'b0);
        check("reset_rx_valid", if_a.rx_valid, 1'b0);
        check("reset_rx_data", if_a.rx_data, 8'h00);
        check("reset_rx_perr", if_a.rx_parity_err, 1'b0);
        check("reset_rx_ferr", if_a.rx_frame_err, 1'b0);
        check("reset_rx_busy", if_a.rx_busy, 1'b0);
        check("reset_tx_b", tx_b, 1'b1);
        check("reset_tx_c", tx_c, 1'b1);

        // 1: 8N1 transmit 0xA5, accept in cycle 0, checked every cycle
        word = 8'hA5;
        if_a.tx_valid = 1'b1;
        if_a.tx_data  = word;
        check("t1_ready_at_accept", if_a.tx_ready, 1'b1);
        for (int n = 1; n <= 330; n++) begin
            logic exp_tx;
            @(negedge clk);
            if_a.tx_valid = 1'b0;
            if (n <= 32)       exp_tx = 1'b0;
            else if (n <= 288) exp_tx = word[(n - 33) / BIT_CYC];
            else               exp_tx = 1'b1;
            check($sformatf("t1_tx_c%0d", n), tx_a, exp_tx);
            check($sformatf("t1_ready_c%0d", n), if_a.tx_ready, (n >= 321));
            check($sformatf("t1_busy_c%0d", n), if_a.tx_busy, (n < 321));
        end

        // 2: 7E2 loopback of 0x3C (four ones -> even parity bit 0)
        b0 = b_cnt;
        @(negedge clk);
        if_b.tx_valid = 1'b1;
        if_b.tx_data  = 7'h3C;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if_b.tx_valid = 1'b0;
            if (n == 272) check("t2_parity_bit", tx_b, 1'b0);
            if (n == 300) check("t2_stop1", tx_b, 1'b1);
            if (n == 340) check("t2_stop2", tx_b, 1'b1);
            if (n == 352) check("t2_ready_c352", if_b.tx_ready, 1'b0);
            if (n == 353) check("t2_ready_c353", if_b.tx_ready, 1'b1);
        end
        check("t2_rx_count", b_cnt - b0, 1);
        check("t2_rx_data", if_b.rx_data, 7'h3C);
        check("t2_rx_perr", if_b.rx_parity_err, 1'b0);
        check("t2_rx_ferr", if_b.rx_frame_err, 1'b0);

        // 3: 8O1 0x00 with wrong parity 0; middle sample of data bit 3 glitched high
        c0 = c_cnt;
        drive_frame(1, 16'h0400, 11, 4 * BIT_CYC + 18);
        drive_level(1, 1'b1, 40);
        check("t3_rx_count", c_cnt - c0, 1);
        check("t3_rx_data", if_c.rx_data, 8'h00);
        check("t3_rx_perr", if_c.rx_parity_err, 1'b1);
        check("t3_rx_ferr", if_c.rx_frame_err, 1'b0);

        // 4: 10-cycle low pulse is a false start
        a0 = a_cnt;
        drive_level(0, 1'b0, 10);
        @(negedge clk);
        check("t4_busy_during", if_a.rx_busy, 1'b1);
        rx_a_drv = 1'b1;
        idle(60);
        check("t4_busy_after", if_a.rx_busy, 1'b0);
        check("t4_no_strobe", a_cnt - a0, 0);

        // 5: 0x55 with stop held low for 5 bit periods, then a clean 0xC3
        a0 = a_cnt;
        drive_frame(0, 16'h00AA, 9, -1);
        drive_level(0, 1'b0, 5 * BIT_CYC);
        check("t5_busy_in_break", if_a.rx_busy, 1'b1);
        drive_level(0, 1'b1, 64);
        check("t5_break_count", a_cnt - a0, 1);
        check("t5_break_data", if_a.rx_data, 8'h55);
        check("t5_break_ferr", if_a.rx_frame_err, 1'b1);
        check("t5_break_perr", if_a.rx_parity_err, 1'b0);
        check("t5_idle_after", if_a.rx_busy, 1'b0);
        drive_frame(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, -1);
        drive_level(0, 1'b1, 40);
        check("t5_clean_count", a_cnt - a0, 2);
        check("t5_clean_data", if_a.rx_data, 8'hC3);
        check("t5_clean_ferr", if_a.rx_frame_err, 1'b0);

        // 6: reset mid-data on both paths of the looped-back 8N1 unit
        loop_a = 1'b1;
        a0 = a_cnt;
        send_a(8'h12);
        idle(98);
        check("t6_tx_before_reset", tx_a, 1'b0);
        check("t6_rx_busy_before", if_a.rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_tx_in_reset", tx_a, 1'b1);
        check("t6_rx_busy_in_reset", if_a.rx_busy, 1'b0);
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after", if_a.tx_ready, 1'b1);
        check("t6_busy_after", if_a.tx_busy, 1'b0);
        idle(400);
        check("t6_no_strobe", a_cnt - a0, 0);
        send_a(8'hFF);
        idle(400);
        check("t6_rt_count", a_cnt - a0, 1);
        check("t6_rt_data", if_a.rx_data, 8'hFF);
        check("t6_rt_ferr", if_a.rx_frame_err, 1'b0);
        check("t6_rt_ready", if_a.tx_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
